// File: rtl/my_down_timer_pkg.sv
// Shared types and constants for the my_down_timer slice-based down counter.
package my_down_timer_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/my_down4.sv
// One 4-bit down-counting slice; decrements only when its borrow-in enable is set.
module my_down4
    import my_down_timer_pkg::*;
(
    input  logic               CP,
    input  logic               CR,
    input  logic               load,
    input  logic [SLICE_W-1:0] load_d,
    input  logic               bin,
    output logic [SLICE_W-1:0] Q,
    output logic               zero
);

    logic [SLICE_W-1:0] q_q;
    logic [SLICE_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_d;
        end else if (bin) begin
            // Wrapping to 4'hF is intended: the upper slice takes the borrow.
            q_d = q_q - SLICE_W'(1);
        end
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q    = q_q;
    assign zero = (q_q == '0);

endmodule

// File: rtl/my_down_timer.sv
// Down timer with parallel load, auto-reload and terminal-count pulse, built from 4-bit slices.
module my_down_timer
    import my_down_timer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CP,
    input  logic         CR,
    input  logic         CTP,
    input  logic         CTT,
    input  logic         LD,
    input  logic         ARL,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q,
    output logic         Bo,
    output logic         TC,
    output logic         BUSY
);

    localparam int NS = W / SLICE_W;

    state_e       state_q, state_d;
    logic [W-1:0] r_q, r_d;
    logic         tc_q, tc_d;
    logic         busy_q, busy_d;
    logic         bo_q, bo_d;

    logic         en;
    logic         dec;
    logic         reload;
    logic         load_en;
    logic [W-1:0] load_val;
    logic [NS-1:0] zero;
    logic [NS-1:0] bin;

    assign en     = CTP & CTT;
    assign dec    = LD & en & (state_q == RUN) & (Q != '0);
    assign reload = LD & en & (state_q == DONE) & ARL & (r_q != '0);

    assign load_en  = ~LD | reload;
    assign load_val = ~LD ? D : r_q;

    // Slice k decrements only when every lower slice already reads zero.
    for (genvar k = 0; k < NS; k++) begin : g_slice
        if (k == 0) begin : g_lsb
            assign bin[k] = dec;
        end else begin : g_upper
            assign bin[k] = dec & (&zero[k-1:0]);
        end

        my_down4 u_slice (
            .CP     (CP),
            .CR     (CR),
            .load   (load_en),
            .load_d (load_val[k*SLICE_W +: SLICE_W]),
            .bin    (bin[k]),
            .Q      (Q[k*SLICE_W +: SLICE_W]),
            .zero   (zero[k])
        );
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        tc_d    = 1'b0;
        bo_d    = (Q == '0);

        if (!LD) begin
            r_d     = D;
            state_d = (D != '0) ? RUN : IDLE;
            bo_d    = (D == '0);
        end else if (en) begin
            case (state_q)
                RUN: begin
                    if (Q == W'(1)) begin
                        state_d = DONE;
                        tc_d    = 1'b1;
                        bo_d    = 1'b1;
                    end else if (Q != '0) begin
                        bo_d = 1'b0;
                    end
                end
                DONE: begin
                    if (reload) begin
                        state_d = RUN;
                        bo_d    = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            state_q <= IDLE;
            r_q     <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            bo_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
            bo_q    <= bo_d;
        end
    end

    assign TC   = tc_q;
    assign BUSY = busy_q;
    assign Bo   = bo_q;

endmodule

// File: tb/tb_my_down_timer.sv
// Directed bench for my_down_timer: a reference model pushes expected outputs to a scoreboard.
module tb_my_down_timer;

    localparam int W = 8;

    logic         CP = 1'b0;
    logic         CR = 1'b1;
    logic         CTP = 1'b0;
    logic         CTT = 1'b0;
    logic         LD = 1'b1;
    logic         ARL = 1'b0;
    logic [W-1:0] D = '0;
    logic [W-1:0] Q;
    logic         Bo;
    logic         TC;
    logic         BUSY;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] q;
        logic         bo;
        logic         tc;
        logic         busy;
        string        tag;
    } exp_t;

    exp_t sb[$];

    // Reference model state: 0 = idle, 1 = run, 2 = done
    int           m_st = 0;
    logic [W-1:0] m_q  = '0;
    logic [W-1:0] m_r  = '0;
    logic         m_tc = 1'b0;

    my_down_timer #(.W(W)) dut (
        .CP   (CP),
        .CR   (CR),
        .CTP  (CTP),
        .CTT  (CTT),
        .LD   (LD),
        .ARL  (ARL),
        .D    (D),
        .Q    (Q),
        .Bo   (Bo),
        .TC   (TC),
        .BUSY (BUSY)
    );

    always #5 CP = ~CP;

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model(input logic cr, input logic ctp, input logic ctt, input logic ld,
                         input logic arl, input logic [W-1:0] d);
        logic en_m;
        en_m = ctp & ctt;
        m_tc = 1'b0;
        if (cr) begin
            m_q = '0; m_r = '0; m_st = 0;
        end else if (!ld) begin
            m_q = d; m_r = d; m_st = (d != 0) ? 1 : 0;
        end else if (en_m) begin
            if (m_st == 1) begin
                if (m_q > 1) begin
                    m_q = m_q - 1;
                end else if (m_q == 1) begin
                    m_q = 0; m_tc = 1'b1; m_st = 2;
                end
            end else if (m_st == 2) begin
                if (arl && m_r != 0) begin
                    m_q = m_r; m_st = 1;
                end
            end
        end
    endtask

    task automatic step(input string tag, input logic cr, input logic ctp, input logic ctt,
                        input logic ld, input logic arl, input logic [W-1:0] d);
        exp_t e;
        exp_t got;
        CR = cr; CTP = ctp; CTT = ctt; LD = ld; ARL = arl; D = d;
        model(cr, ctp, ctt, ld, arl, d);
        e.q = m_q; e.bo = (m_q == 0); e.tc = m_tc; e.busy = (m_st == 1); e.tag = tag;
        sb.push_back(e);
        @(posedge CP);
        #1;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s_sb: observed %0d entries expected nonzero", tag, sb.size());
        end
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check_val({got.tag, "_q"}, Q, got.q);
            check_val({got.tag, "_bo"}, W'(Bo), W'(got.bo));
            check_val({got.tag, "_tc"}, W'(TC), W'(got.tc));
            check_val({got.tag, "_busy"}, W'(BUSY), W'(got.busy));
        end
    endtask

    initial begin
        // Reset, then reset with LD low and en high in the same cycle
        step("rst", 1, 0, 0, 1, 0, 8'h00);
        step("rst_ld", 1, 1, 1, 0, 1, 8'h55);
        check_val("rst_q_const", Q, 8'h00);
        step("idle_en", 0, 1, 1, 1, 1, 8'h00);

        // Load 3, count down to zero, then hold in DONE
        step("ld3", 0, 1, 1, 0, 0, 8'h03);
        for (int i = 0; i < 4; i++) step("cnt3", 0, 1, 1, 1, 0, 8'h00);
        check_val("cnt3_bo_const", W'(Bo), W'(1));
        step("done_arl_noen", 0, 0, 1, 1, 1, 8'h00);

        // Auto-reload with period R+1
        step("ld2_arl", 0, 1, 1, 0, 1, 8'h02);
        for (int i = 0; i < 6; i++) step("arl", 0, 1, 1, 1, 1, 8'h00);

        // Borrow across slices, then CTT low holds the count
        step("ld10", 0, 1, 1, 0, 0, 8'h10);
        step("borrow", 0, 1, 1, 1, 0, 8'h00);
        check_val("borrow_const", Q, 8'h0F);
        for (int i = 0; i < 3; i++) step("ctt_hold", 0, 1, 0, 1, 0, 8'h00);
        check_val("hold_const", Q, 8'h0F);

        // Load coincides with the 1->0 edge
        step("ld2b", 0, 1, 1, 0, 0, 8'h02);
        step("to1", 0, 1, 1, 1, 0, 8'h00);
        step("ld_over_tc", 0, 1, 1, 0, 0, 8'h05);
        check_val("ld_over_tc_const", Q, 8'h05);
        step("after_ld5", 0, 1, 1, 1, 0, 8'h00);

        // Reset mid-count with LD low wins
        step("ld40", 0, 1, 1, 0, 0, 8'h40);
        step("run40", 0, 0, 0, 1, 0, 8'h00);
        step("cr_mid", 1, 1, 1, 0, 0, 8'h07);
        check_val("cr_mid_const", Q, 8'h00);

        // Load zero: stays idle, never decrements
        step("ld0", 0, 1, 1, 0, 1, 8'h00);
        for (int i = 0; i < 5; i++) step("idle0", 0, 1, 1, 1, 1, 8'h00);

        // Larger value through the upper-slice wrap
        step("ld21", 0, 1, 1, 0, 0, 8'h21);
        for (int i = 0; i < 3; i++) step("cnt21", 0, 1, 1, 1, 0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
